bus_if: RTL and testbench
=========================

// Module: bus_if
// PURPOSE
//  AXI4-Lite-style write-channel slave endpoint with a small word-addressed register bank.
//  Accepts independent AW and W channel handshakes, commits the write, and returns a B response.
//  Sits behind a bus master (CPU/testbench driver); exposes a combinational sideband read port.
//  Supports register readback and scoreboard checks.
// PARAMETERS
//  ADDR_W     32          address width (bits)
//  DATA_W     32          data width (bits); multiple of 8; STRB_W = DATA_W/8
//  BASE_ADDR  'h0000_1000 byte address of register 0
//  DEPTH      16          number of DATA_W-bit registers (power of 2, >=2)
// PORTS
//  clk      in   1                 clock, all state updates on rising edge
//  rst_n    in   1                 asynchronous active-low reset
//  awaddr   in   ADDR_W            write byte address
//  awvalid  in   1                 write address valid
//  awready  out  1                 write address ready
//  wdata    in   DATA_W            write data
//  wstrb    in   DATA_W/8          byte-lane write strobes
//  wvalid   in   1                 write data valid
//  wready   out  1                 write data ready
//  bresp    out  2                 write response: 0=OKAY, 2=SLVERR
//  bvalid   out  1                 write response valid
//  bready   in   1                 write response ready
//  rd_idx   in   $clog2(DEPTH)     sideband register index
//  rd_data  out  DATA_W            register[rd_idx], combinational
// BEHAVIOUR
//  Reset (async, rst_n=0): aw_held=0, w_held=0, bvalid=0, bresp=0, all registers=0.
//  Reset outputs: awready=1, wready=1.
//  Reset mid-transaction discards held address/data; no register write occurs.
//  Readiness: awready = !aw_held && !bvalid; wready = !w_held && !bvalid (combinational from flops).
//  AW handshake (awvalid&&awready at edge): latch awaddr, set aw_held.
//  W handshake (wvalid&&wready at edge): latch wdata/wstrb, set w_held.
//  Each channel accepts exactly one beat per transaction.
//  A valid held high after its handshake is ignored until the B handshake completes.
//  Channel order is free: AW first, W first, or both in the same cycle.
//  Commit: on the edge where both AW and W are held (or completing this edge):
//   - Decode the address; update registers per strobes.
//   - Set bvalid=1 and bresp; clear aw_held/w_held.
//   - bvalid is visible the cycle after the last handshake (1-cycle latency).
//  Decode: off = addr - BASE_ADDR.
//   - OKAY if addr >= BASE_ADDR, off < 4*DEPTH and addr[1:0]==0.
//   - Otherwise SLVERR, with no register change.
//  Write: for each lane i with wstrb[i]=1, reg[off>>2][8i+:8] <= wdata[8i+:8]; other lanes unchanged.
//   - wstrb=0 -> OKAY, no change.
//  B channel: bvalid/bresp stay stable until bvalid&&bready at an edge, then bvalid=0.
//   - bready may be low for any number of cycles.
//   - No new AW/W is accepted while bvalid=1 (single outstanding transaction).
//  Sideband read reflects the register value after each commit edge.
//  A write and a sideband read of the same index in one cycle returns the old value.
//  No arithmetic overflow: decode compares in ADDR_W+1 bits so addresses below BASE_ADDR never wrap into range.
// TESTING
//  1. Writes with AW+W same cycle, wstrb=F, bready raised after:
//     0x1000<-0x12345678, 0x1004<-0xAAAABBBB, 0x1008<-0xCCCCDDDD.
//     -> each bresp=0; rd_idx 0/1/2 read back those values.
//  2. AW 0x100C alone, W 0xDEADBEEF three cycles later.
//     -> awready low after AW; bvalid 1 cycle after W; reg[3]=0xDEADBEEF.
//  3. Write 0x1000 <- 0xFFFFFFFF with wstrb=4'b0011 after test 1.
//     -> reg[0]=0x1234FFFF, bresp=0.
//  4. Write 0x2000 and 0x0FFC, then 0x1002.
//     -> bresp=2 each; no register changes.
//  5. Hold bready=0 for 5 cycles after commit.
//     -> bvalid, bresp stable; awready=wready=0; awvalid kept high is not re-accepted.
//  6. Assert rst_n=0 after AW handshake, before W.
//     -> bvalid=0, awready=wready=1; registers all 0; no write.

Source files
------------

// File: rtl/bus_if.sv
// Write-channel slave endpoint: accepts AW and W beats in either order, commits to a register bank, returns B.
// Latency: bvalid is asserted the cycle after the later of the AW/W handshakes; rd_data is combinational.
// Backpressure: awready/wready drop once their beat is held and stay low while a B response is outstanding.
//
// Ports:
//   clk, rst_n                    clock, asynchronous active-low reset
//   awaddr/awvalid/awready        write address channel
//   wdata/wstrb/wvalid/wready     write data channel with byte-lane strobes
//   bresp/bvalid/bready           write response channel (0=OKAY, 2=SLVERR)
//   rd_idx/rd_data                sideband combinational register read
module bus_if #(
  parameter int                ADDR_W    = 32,
  parameter int                DATA_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = 'h0000_1000,
  parameter int                DEPTH     = 16,
  localparam int               STRB_W    = DATA_W / 8,
  localparam int               IDX_W     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] awaddr,
  input  logic              awvalid,
  output logic              awready,
  input  logic [DATA_W-1:0] wdata,
  input  logic [STRB_W-1:0] wstrb,
  input  logic              wvalid,
  output logic              wready,
  output logic [1:0]        bresp,
  output logic              bvalid,
  input  logic              bready,
  input  logic [IDX_W-1:0]  rd_idx,
  output logic [DATA_W-1:0] rd_data
);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Byte span of the register window, in the widened decode width.
  localparam logic [ADDR_W:0] SPAN = (ADDR_W+1)'(4 * DEPTH);

  logic              r_aw_held;
  logic [ADDR_W-1:0] r_awaddr;
  logic              r_w_held;
  logic [DATA_W-1:0] r_wdata;
  logic [STRB_W-1:0] r_wstrb;
  logic              r_bvalid;
  logic [1:0]        r_bresp;
  logic [DATA_W-1:0] r_regs [DEPTH];

  logic              w_aw_hs;
  logic              w_w_hs;
  logic              w_commit;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_data;
  logic [STRB_W-1:0] w_strb;
  logic [ADDR_W:0]   w_addr_ext;
  logic [ADDR_W:0]   w_base_ext;
  logic [ADDR_W:0]   w_off;
  logic              w_ok;
  logic [IDX_W-1:0]  w_idx;

  assign awready = !r_aw_held && !r_bvalid;
  assign wready  = !r_w_held  && !r_bvalid;
  assign bvalid  = r_bvalid;
  assign bresp   = r_bresp;
  assign rd_data = r_regs[rd_idx];

  assign w_aw_hs  = awvalid && awready;
  assign w_w_hs   = wvalid  && wready;
  assign w_commit = (r_aw_held || w_aw_hs) && (r_w_held || w_w_hs);

  // A beat completing on this edge has not been latched yet, so take it from the bus.
  assign w_addr = r_aw_held ? r_awaddr : awaddr;
  assign w_data = r_w_held  ? r_wdata  : wdata;
  assign w_strb = r_w_held  ? r_wstrb  : wstrb;

  // One extra bit keeps addresses below the base from wrapping into the window.
  assign w_addr_ext = {1'b0, w_addr};
  assign w_base_ext = {1'b0, BASE_ADDR};
  assign w_off      = w_addr_ext - w_base_ext;
  assign w_ok       = (w_addr_ext >= w_base_ext) && (w_off < SPAN) && (w_addr[1:0] == 2'b00);
  assign w_idx      = w_off[IDX_W+1:2];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_aw_held <= 1'b0;
      r_awaddr  <= '0;
      r_w_held  <= 1'b0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
      r_bvalid  <= 1'b0;
      r_bresp   <= RESP_OKAY;
      for (int i = 0; i < DEPTH; i++) begin
        r_regs[i] <= '0;
      end
    end else begin
      if (w_aw_hs) begin
        r_aw_held <= 1'b1;
        r_awaddr  <= awaddr;
      end
      if (w_w_hs) begin
        r_w_held <= 1'b1;
        r_wdata  <= wdata;
        r_wstrb  <= wstrb;
      end
      if (w_commit) begin
        // Commit overrides the held-flag sets above when a beat completes this edge.
        r_aw_held <= 1'b0;
        r_w_held  <= 1'b0;
        r_bvalid  <= 1'b1;
        r_bresp   <= w_ok ? RESP_OKAY : RESP_SLVERR;
        if (w_ok) begin
          for (int i = 0; i < STRB_W; i++) begin
            if (w_strb[i]) begin
              r_regs[w_idx][8*i +: 8] <= w_data[8*i +: 8];
            end
          end
        end
      end else if (r_bvalid && bready) begin
        r_bvalid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_bus_if.sv
module tb_bus_if;

  logic        clk;
  logic        rst_n;
  logic [31:0] awaddr;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [3:0]  rd_idx;
  logic [31:0] rd_data;

  int n_checks = 0;
  int n_errors = 0;

  // Reference register bank, updated from the address/strobe rules directly.
  logic [31:0] mdl [16];

  bus_if dut (
    .clk(clk), .rst_n(rst_n),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .rd_idx(rd_idx), .rd_data(rd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [1:0] model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    longint unsigned ua = a;
    int idx;
    if (ua >= 64'h1000 && (ua - 64'h1000) < 64 && (ua % 4) == 0) begin
      idx = int'((ua - 64'h1000) / 4);
      for (int l = 0; l < 4; l++)
        if (s[l]) mdl[idx][8*l +: 8] = d[8*l +: 8];
      return 2'd0;
    end
    return 2'd2;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one write with chosen channel delays and bready stall; reports what it saw.
  task automatic drive_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                             input int aw_dly, input int w_dly, input int b_dly,
                             output logic [1:0] resp, output bit lat_ok,
                             output bit stable_ok, output bit done_ok);
    bit aw_done = 0, w_done = 0, hs_aw, hs_w, early = 0;
    int cyc = 0;
    stable_ok = 1;
    awaddr = a; wdata = d; wstrb = s;
    while (!(aw_done && w_done) && cyc < 50) begin
      awvalid = !aw_done && (cyc >= aw_dly);
      wvalid  = !w_done  && (cyc >= w_dly);
      hs_aw = awvalid && awready;
      hs_w  = wvalid && wready;
      tick();
      cyc++;
      aw_done |= hs_aw;
      w_done  |= hs_w;
      if (!(aw_done && w_done) && bvalid) early = 1;
    end
    awvalid = 0; wvalid = 0;
    lat_ok = aw_done && w_done && (bvalid === 1'b1) && !early;
    resp = bresp;
    for (int k = 0; k < b_dly; k++) begin
      tick();
      if (bvalid !== 1'b1 || bresp !== resp || awready !== 1'b0 || wready !== 1'b0) stable_ok = 0;
    end
    bready = 1;
    tick();
    bready = 0;
    done_ok = (bvalid === 1'b0) && (awready === 1'b1) && (wready === 1'b1);
  endtask

  task automatic test_reset();
    rst_n = 0;
    #3;
    n_checks++; if (awready !== 1'b1) begin n_errors++; $display("FAIL reset_awready got=%b exp=1", awready); end
    n_checks++; if (wready !== 1'b1) begin n_errors++; $display("FAIL reset_wready got=%b exp=1", wready); end
    n_checks++; if (bvalid !== 1'b0) begin n_errors++; $display("FAIL reset_bvalid got=%b exp=0", bvalid); end
    n_checks++; if (bresp !== 2'd0) begin n_errors++; $display("FAIL reset_bresp got=%0d exp=0", bresp); end
    for (int i = 0; i < 16; i++) begin
      rd_idx = 4'(i); #1;
      n_checks++; if (rd_data !== 32'h0) begin n_errors++; $display("FAIL reset_reg[%0d] got=%h exp=0", i, rd_data); end
    end
    @(posedge clk); #1;
    rst_n = 1;
    tick();
  endtask

  task automatic test_basic();
    logic [31:0] addrs [3] = '{32'h1000, 32'h1004, 32'h1008};
    logic [31:0] datas [3] = '{32'h12345678, 32'hAAAABBBB, 32'hCCCCDDDD};
    logic [1:0] resp, exp;
    bit lat, stab, done;
    for (int i = 0; i < 3; i++) begin
      exp = model_write(addrs[i], datas[i], 4'hF);
      drive_write(addrs[i], datas[i], 4'hF, 0, 0, 2, resp, lat, stab, done);
      n_checks++; if (resp !== exp) begin n_errors++; $display("FAIL basic_bresp[%0d] got=%0d exp=%0d", i, resp, exp); end
      n_checks++; if (!lat) begin n_errors++; $display("FAIL basic_latency[%0d] got=late exp=1cycle", i); end
      n_checks++; if (!(stab && done)) begin n_errors++; $display("FAIL basic_bchan[%0d] got=stable%0d/done%0d exp=1/1", i, stab, done); end
    end
    for (int i = 0; i < 3; i++) begin
      rd_idx = 4'(i); #1;
      n_checks++; if (rd_data !== mdl[i]) begin n_errors++; $display("FAIL basic_read[%0d] got=%h exp=%h", i, rd_data, mdl[i]); end
    end
  endtask

  task automatic test_aw_first();
    logic [1:0] exp;
    exp = model_write(32'h100C, 32'hDEADBEEF, 4'hF);
    awaddr = 32'h100C; awvalid = 1;
    tick();
    awvalid = 0;
    n_checks++; if (awready !== 1'b0) begin n_errors++; $display("FAIL awfirst_awready got=%b exp=0", awready); end
    n_checks++; if (wready !== 1'b1) begin n_errors++; $display("FAIL awfirst_wready got=%b exp=1", wready); end
    tick(); tick();
    n_checks++; if (bvalid !== 1'b0) begin n_errors++; $display("FAIL awfirst_bvalid_early got=%b exp=0", bvalid); end
    wdata = 32'hDEADBEEF; wstrb = 4'hF; wvalid = 1;
    tick();
    wvalid = 0;
    n_checks++; if (bvalid !== 1'b1 || bresp !== exp) begin n_errors++; $display("FAIL awfirst_b got=%b/%0d exp=1/%0d", bvalid, bresp, exp); end
    bready = 1; tick(); bready = 0;
    rd_idx = 4'd3; #1;
    n_checks++; if (rd_data !== 32'hDEADBEEF) begin n_errors++; $display("FAIL awfirst_reg3 got=%h exp=deadbeef", rd_data); end
  endtask

  task automatic test_strobe();
    logic [1:0] exp;
    exp = model_write(32'h1000, 32'hFFFFFFFF, 4'b0011);
    rd_idx = 4'd0;
    awaddr = 32'h1000; wdata = 32'hFFFFFFFF; wstrb = 4'b0011;
    awvalid = 1; wvalid = 1;
    #1;
    n_checks++; if (rd_data !== 32'h12345678) begin n_errors++; $display("FAIL strobe_old_value got=%h exp=12345678", rd_data); end
    tick();
    awvalid = 0; wvalid = 0;
    n_checks++; if (rd_data !== mdl[0]) begin n_errors++; $display("FAIL strobe_reg0 got=%h exp=%h", rd_data, mdl[0]); end
    n_checks++; if (bvalid !== 1'b1 || bresp !== exp) begin n_errors++; $display("FAIL strobe_b got=%b/%0d exp=1/%0d", bvalid, bresp, exp); end
    bready = 1; tick(); bready = 0;
  endtask

  task automatic test_slverr();
    logic [31:0] addrs [4] = '{32'h2000, 32'h0FFC, 32'h1002, 32'h1040};
    logic [1:0] resp, exp;
    bit lat, stab, done;
    for (int i = 0; i < 4; i++) begin
      exp = model_write(addrs[i], 32'h5A5A5A5A, 4'hF);
      drive_write(addrs[i], 32'h5A5A5A5A, 4'hF, i % 2, (i + 1) % 2, 0, resp, lat, stab, done);
      n_checks++; if (resp !== exp) begin n_errors++; $display("FAIL slverr_bresp[%h] got=%0d exp=%0d", addrs[i], resp, exp); end
    end
    for (int i = 0; i < 16; i++) begin
      rd_idx = 4'(i); #1;
      n_checks++; if (rd_data !== mdl[i]) begin n_errors++; $display("FAIL slverr_reg[%0d] got=%h exp=%h", i, rd_data, mdl[i]); end
    end
  endtask

  task automatic test_bready_stall();
    logic [1:0] exp;
    exp = model_write(32'h1010, 32'h0BADF00D, 4'hF);
    awaddr = 32'h1010; wdata = 32'h0BADF00D; wstrb = 4'hF;
    awvalid = 1; wvalid = 1;
    tick();
    // Valids stay high with new payload; the slave must not take it.
    awaddr = 32'h1014; wdata = 32'h11111111;
    for (int k = 0; k < 5; k++) begin
      n_checks++;
      if (bvalid !== 1'b1 || bresp !== exp || awready !== 1'b0 || wready !== 1'b0) begin
        n_errors++;
        $display("FAIL stall_cycle%0d got=bv%b br%0d awr%b wr%b exp=bv1 br%0d awr0 wr0", k, bvalid, bresp, awready, wready, exp);
      end
      tick();
    end
    awvalid = 0; wvalid = 0; bready = 1;
    tick();
    bready = 0;
    n_checks++; if (bvalid !== 1'b0 || awready !== 1'b1 || wready !== 1'b1) begin n_errors++; $display("FAIL stall_release got=bv%b awr%b wr%b exp=bv0 awr1 wr1", bvalid, awready, wready); end
    rd_idx = 4'd4; #1;
    n_checks++; if (rd_data !== mdl[4]) begin n_errors++; $display("FAIL stall_reg4 got=%h exp=%h", rd_data, mdl[4]); end
    rd_idx = 4'd5; #1;
    n_checks++; if (rd_data !== mdl[5]) begin n_errors++; $display("FAIL stall_reg5 got=%h exp=%h", rd_data, mdl[5]); end
  endtask

  task automatic test_random();
    logic [31:0] a, d;
    logic [3:0] s;
    logic [1:0] resp, exp;
    bit lat, stab, done;
    for (int t = 0; t < 60; t++) begin
      case ($urandom_range(0, 9))
        0: a = 32'h1000 + 4 * $urandom_range(0, 15) + $urandom_range(1, 3);
        1: a = 32'h1040 + 4 * $urandom_range(0, 15);
        2: a = 32'h1000 - 4 * $urandom_range(1, 4);
        3: a = $urandom();
        default: a = 32'h1000 + 4 * $urandom_range(0, 15);
      endcase
      d = $urandom();
      s = 4'($urandom_range(0, 15));
      exp = model_write(a, d, s);
      drive_write(a, d, s, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), resp, lat, stab, done);
      n_checks++;
      if (resp !== exp || !lat || !stab || !done) begin
        n_errors++;
        $display("FAIL random[%0d] addr=%h got=resp%0d lat%0d stab%0d done%0d exp=resp%0d lat1 stab1 done1", t, a, resp, lat, stab, done, exp);
      end
      if (t % 10 == 9) begin
        for (int i = 0; i < 16; i++) begin
          rd_idx = 4'(i); #1;
          n_checks++; if (rd_data !== mdl[i]) begin n_errors++; $display("FAIL random_reg[%0d] got=%h exp=%h", i, rd_data, mdl[i]); end
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    awaddr = 32'h1000; awvalid = 1;
    tick();
    awvalid = 0;
    #2;
    rst_n = 0;
    #1;
    for (int i = 0; i < 16; i++) mdl[i] = 32'h0;
    n_checks++; if (bvalid !== 1'b0 || awready !== 1'b1 || wready !== 1'b1) begin n_errors++; $display("FAIL rstmid_outputs got=bv%b awr%b wr%b exp=bv0 awr1 wr1", bvalid, awready, wready); end
    for (int i = 0; i < 16; i++) begin
      rd_idx = 4'(i); #1;
      n_checks++; if (rd_data !== 32'h0) begin n_errors++; $display("FAIL rstmid_reg[%0d] got=%h exp=0", i, rd_data); end
    end
    @(posedge clk); #1;
    rst_n = 1;
    tick();
    // The address held before reset must be gone: a lone W beat cannot commit.
    wdata = 32'hCAFEF00D; wstrb = 4'hF; wvalid = 1;
    tick();
    wvalid = 0;
    rd_idx = 4'd0; #1;
    n_checks++; if (bvalid !== 1'b0 || rd_data !== 32'h0) begin n_errors++; $display("FAIL rstmid_no_write got=bv%b reg0=%h exp=bv0 reg0=0", bvalid, rd_data); end
    n_checks++; if (awready !== 1'b1 || wready !== 1'b0) begin n_errors++; $display("FAIL rstmid_ready got=awr%b wr%b exp=awr1 wr0", awready, wready); end
    void'(model_write(32'h1004, 32'hCAFEF00D, 4'hF));
    awaddr = 32'h1004; awvalid = 1;
    tick();
    awvalid = 0;
    n_checks++; if (bvalid !== 1'b1 || bresp !== 2'd0) begin n_errors++; $display("FAIL rstmid_commit got=bv%b br%0d exp=bv1 br0", bvalid, bresp); end
    bready = 1; tick(); bready = 0;
    rd_idx = 4'd1; #1;
    n_checks++; if (rd_data !== mdl[1]) begin n_errors++; $display("FAIL rstmid_reg1 got=%h exp=%h", rd_data, mdl[1]); end
  endtask

  initial begin
    awaddr = '0; awvalid = 0; wdata = '0; wstrb = '0; wvalid = 0; bready = 0; rd_idx = '0;
    for (int i = 0; i < 16; i++) mdl[i] = 32'h0;
    test_reset();
    test_basic();
    test_aw_first();
    test_strobe();
    test_slverr();
    test_bready_stall();
    test_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
